// File: rtl/odd_even_stream_classifier.sv
// odd_even_stream_classifier
// Valid/ready stream stage that registers each WIDTH-bit sample with its
// odd/even flag and keeps saturating per-frame even/odd counts. A sample
// accepted with in_last publishes the frame totals and pulses frame_done.
// Optional feature macro: ODD_EVEN_PARITY_EN (registers ^in_data on out_parity;
// when undefined out_parity is tied to 0).
module odd_even_stream_classifier #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_is_even,
   output logic             out_parity,
   output logic             frame_done,
   output logic [CNT_W-1:0] even_count,
   output logic [CNT_W-1:0] odd_count
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_is_even;
   logic             r_frame_done;
   logic [CNT_W-1:0] r_even_count;
   logic [CNT_W-1:0] r_odd_count;
   logic [CNT_W-1:0] r_ev_acc;
   logic [CNT_W-1:0] r_od_acc;

   logic             w_accept;
   logic             w_in_even;
   logic [CNT_W-1:0] w_ev_sum;
   logic [CNT_W-1:0] w_od_sum;

   // Single output register: room exists when it is empty or being drained now.
   assign in_ready  = !r_out_valid || out_ready;
   assign w_accept  = in_valid && in_ready;
   assign w_in_even = ~in_data[0];

   // Running totals including the current sample, held at all-ones once saturated.
   assign w_ev_sum = (w_in_even && (r_ev_acc != CntMax)) ? r_ev_acc + CntOne : r_ev_acc;
   assign w_od_sum = (!w_in_even && (r_od_acc != CntMax)) ? r_od_acc + CntOne : r_od_acc;

   // Output sample register; contents only change on accept so they hold under stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_out_is_even <= 1'b1;
      end else begin
         r_out_valid <= w_accept || (r_out_valid && !out_ready);
         if (w_accept) begin
            r_out_data    <= in_data;
            r_out_is_even <= w_in_even;
         end
      end
   end

   // Frame accumulators and published summary; in_last closes the frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frame_done <= 1'b0;
         r_even_count <= '0;
         r_odd_count  <= '0;
         r_ev_acc     <= '0;
         r_od_acc     <= '0;
      end else begin
         r_frame_done <= w_accept && in_last;
         if (w_accept) begin
            if (in_last) begin
               r_even_count <= w_ev_sum;
               r_odd_count  <= w_od_sum;
               r_ev_acc     <= '0;
               r_od_acc     <= '0;
            end else begin
               r_ev_acc <= w_ev_sum;
               r_od_acc <= w_od_sum;
            end
         end
      end
   end

`ifdef ODD_EVEN_PARITY_EN
   logic r_out_parity;

   // Parity of the accepted sample, loaded alongside the data register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_parity <= 1'b0;
      end else if (w_accept) begin
         r_out_parity <= ^in_data;
      end
   end

   assign out_parity = r_out_parity;
`else
   assign out_parity = 1'b0;
`endif

   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_is_even = r_out_is_even;
   assign frame_done  = r_frame_done;
   assign even_count  = r_even_count;
   assign odd_count   = r_odd_count;

endmodule

// File: tb/tb_odd_even_stream_classifier.sv
// Bench for odd_even_stream_classifier: table-driven stream on an 8/8 instance
// with a scoreboard, plus hand sequences on CNT_W=2 and WIDTH=1 instances.
module tb_odd_even_stream_classifier;

`ifdef ODD_EVEN_PARITY_EN
   localparam logic ParEn = 1'b1;
`else
   localparam logic ParEn = 1'b0;
`endif

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       last;
      logic       oready;
      logic       even;
      logic       par;
      logic [7:0] ev;
      logic [7:0] od;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       even;
      logic       par;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   logic       a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready;
   logic [7:0] a_in_data, a_out_data, a_even_count, a_odd_count;
   logic       a_out_is_even, a_out_parity, a_frame_done;

   logic       b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready;
   logic [7:0] b_in_data, b_out_data;
   logic [1:0] b_even_count, b_odd_count;
   logic       b_out_is_even, b_out_parity, b_frame_done;

   logic       c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready;
   logic [0:0] c_in_data, c_out_data;
   logic [7:0] c_even_count, c_odd_count;
   logic       c_out_is_even, c_out_parity, c_frame_done;

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs[14];
   vec_t cur;
   exp_t sb[$];
   logic exp_fd = 1'b0;
   logic [7:0] fd_ev, fd_od;

   always #5 clk = ~clk;

   odd_even_stream_classifier #(.WIDTH(8), .CNT_W(8)) u_a (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_data(a_out_data), .out_is_even(a_out_is_even),
      .out_parity(a_out_parity), .frame_done(a_frame_done),
      .even_count(a_even_count), .odd_count(a_odd_count)
   );

   odd_even_stream_classifier #(.WIDTH(8), .CNT_W(2)) u_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .out_is_even(b_out_is_even),
      .out_parity(b_out_parity), .frame_done(b_frame_done),
      .even_count(b_even_count), .odd_count(b_odd_count)
   );

   odd_even_stream_classifier #(.WIDTH(1), .CNT_W(8)) u_c (
      .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
      .out_ready(c_out_ready), .out_data(c_out_data), .out_is_even(c_out_is_even),
      .out_parity(c_out_parity), .frame_done(c_frame_done),
      .even_count(c_even_count), .odd_count(c_odd_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic l,
                               input logic r, input logic e, input logic p,
                               input logic [7:0] ev, input logic [7:0] od);
      vec_t x;
      x.valid = v; x.data = d; x.last = l; x.oready = r;
      x.even = e; x.par = p; x.ev = ev; x.od = od;
      return x;
   endfunction

   // Present one vector on instance A; valid vectors are held until accepted.
   task automatic drive(input vec_t v);
      int n;
      n = 0;
      @(posedge clk); #1;
      a_in_valid  = v.valid;
      a_in_data   = v.data;
      a_in_last   = v.last;
      a_out_ready = v.oready;
      cur         = v;
      @(negedge clk);
      if (v.valid) begin
         while (!a_in_ready && n < 16) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
         end
         if (!a_in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready got 0, expected 1 within 16 cycles");
         end
      end
   endtask

   task automatic b_send(input logic [7:0] d, input logic l);
      @(posedge clk); #1;
      b_in_valid = 1'b1; b_in_data = d; b_in_last = l;
   endtask

   task automatic c_send(input logic d, input logic l);
      @(posedge clk); #1;
      c_in_valid = 1'b1; c_in_data = d; c_in_last = l;
   endtask

   // Scoreboard for instance A: push on accept, pop on output transfer.
   always @(negedge clk) begin
      if (!reset) begin
         sb.delete();
         exp_fd = 1'b0;
      end else begin
         check("frame_done", {31'd0, a_frame_done}, {31'd0, exp_fd});
         if (a_frame_done && exp_fd) begin
            check("even_count", {24'd0, a_even_count}, {24'd0, fd_ev});
            check("odd_count", {24'd0, a_odd_count}, {24'd0, fd_od});
         end
         check("in_ready", {31'd0, a_in_ready}, {31'd0, (!a_out_valid || a_out_ready)});
         if (a_out_valid && a_out_ready) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_empty: got output %0h, expected no output", a_out_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_data", {24'd0, a_out_data}, {24'd0, e.data});
               check("out_is_even", {31'd0, a_out_is_even}, {31'd0, e.even});
               check("out_parity", {31'd0, a_out_parity}, {31'd0, e.par});
            end
         end
         exp_fd = 1'b0;
         if (a_in_valid && a_in_ready) begin
            exp_t e;
            e.data = cur.data;
            e.even = cur.even;
            e.par  = cur.par & ParEn;
            sb.push_back(e);
            if (cur.last) begin
               exp_fd = 1'b1;
               fd_ev  = cur.ev;
               fd_od  = cur.od;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(1, 8'h06, 0, 1, 1, 0, 0, 0);
      vecs[1]  = mk(1, 8'h0B, 1, 1, 0, 1, 1, 1);
      vecs[2]  = mk(0, 8'h00, 0, 1, 0, 0, 0, 0);
      vecs[3]  = mk(1, 8'hB7, 0, 1, 0, 0, 0, 0);
      vecs[4]  = mk(1, 8'h07, 0, 1, 0, 1, 0, 0);
      vecs[5]  = mk(0, 8'h00, 0, 0, 0, 0, 0, 0);
      vecs[6]  = mk(1, 8'h10, 0, 1, 1, 1, 0, 0);
      vecs[7]  = mk(1, 8'h22, 1, 1, 1, 0, 2, 2);
      vecs[8]  = mk(0, 8'h00, 0, 1, 0, 0, 0, 0);
      vecs[9]  = mk(1, 8'h80, 1, 1, 1, 1, 1, 0);
      vecs[10] = mk(1, 8'h01, 1, 1, 0, 1, 0, 1);
      vecs[11] = mk(1, 8'h33, 0, 1, 0, 0, 0, 0);
      vecs[12] = mk(1, 8'h44, 1, 1, 1, 0, 1, 1);
      vecs[13] = mk(0, 8'h00, 0, 1, 0, 0, 0, 0);

      reset = 1'b0;
      a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 1;
      c_in_valid = 0; c_in_data = 0; c_in_last = 0; c_out_ready = 1;
      cur = vecs[2];

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, a_out_valid}, 0);
      check("rst_out_data", {24'd0, a_out_data}, 0);
      check("rst_out_is_even", {31'd0, a_out_is_even}, 1);
      check("rst_out_parity", {31'd0, a_out_parity}, 0);
      check("rst_frame_done", {31'd0, a_frame_done}, 0);
      check("rst_counts", {16'd0, a_even_count, a_odd_count}, 0);
      check("rst_in_ready", {31'd0, a_in_ready}, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, a_in_ready}, 1);

      // Reset mid-frame discards the partial frame
      drive(mk(1, 8'h06, 0, 1, 1, 0, 0, 0));
      drive(mk(1, 8'h0B, 0, 1, 0, 1, 0, 0));
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      reset = 1'b0;
      #2;
      check("midrst_out_valid", {31'd0, a_out_valid}, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      drive(mk(1, 8'h04, 1, 1, 1, 1, 1, 0));
      drive(vecs[2]);

      // Table-driven stream
      for (int i = 0; i < 14; i++) drive(vecs[i]);

      // Backpressure: 9 held under stall, then 2 replaces it with out_valid kept high
      drive(mk(1, 8'h09, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) begin
         drive(mk(0, 8'h00, 0, 0, 0, 0, 0, 0));
         check("bp_hold_data", {24'd0, a_out_data}, 32'h09);
         check("bp_in_ready", {31'd0, a_in_ready}, 0);
      end
      drive(mk(1, 8'h02, 0, 1, 1, 1, 0, 0));
      drive(mk(0, 8'h00, 0, 0, 0, 0, 0, 0));
      check("bp_valid_kept", {31'd0, a_out_valid}, 1);
      check("bp_new_data", {24'd0, a_out_data}, 32'h02);
      drive(mk(1, 8'h55, 1, 1, 0, 0, 1, 2));
      drive(vecs[2]);
      drive(vecs[2]);
      check("sb_drained", sb.size(), 0);

      // Saturation on CNT_W = 2
      b_send(8'd2, 0);
      b_send(8'd4, 0);
      check("sat_b_fd_mid", {31'd0, b_frame_done}, 0);
      check("sat_b_data", {24'd0, b_out_data}, 32'd2);
      check("sat_b_in_ready", {31'd0, b_in_ready}, 1);
      b_send(8'd6, 0);
      b_send(8'd8, 0);
      b_send(8'd10, 1);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      @(negedge clk);
      check("sat_b_fd", {31'd0, b_frame_done}, 1);
      check("sat_b_even", {30'd0, b_even_count}, 3);
      check("sat_b_odd", {30'd0, b_odd_count}, 0);
      b_send(8'd7, 1);
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      @(negedge clk);
      check("sat_b2_fd", {31'd0, b_frame_done}, 1);
      check("sat_b2_counts", {28'd0, b_even_count, b_odd_count}, 32'h1);
      check("sat_b2_parity", {31'd0, b_out_parity}, {31'd0, ParEn});
      repeat (2) @(negedge clk);
      check("sat_b2_fd_once", {31'd0, b_frame_done}, 0);
      check("sat_b2_hold", {28'd0, b_even_count, b_odd_count}, 32'h1);

      // WIDTH = 1 instance
      c_send(1'b0, 0);
      c_send(1'b1, 0);
      check("w1_is_even0", {31'd0, c_out_is_even}, 1);
      c_send(1'b0, 1);
      check("w1_is_even1", {31'd0, c_out_is_even}, 0);
      @(posedge clk); #1;
      c_in_valid = 1'b0;
      check("w1_is_even2", {31'd0, c_out_is_even}, 1);
      check("w1_fd", {31'd0, c_frame_done}, 1);
      check("w1_even", {24'd0, c_even_count}, 2);
      check("w1_odd", {24'd0, c_odd_count}, 1);
      check("w1_valid", {31'd0, c_out_valid & c_in_ready}, 1);
      check("w1_data", {31'd0, c_out_data}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/odd_even_stream_classifier.md
# odd_even_stream_classifier

Streaming, parametrised successor to the 8-bit combinational odd/even checker. It accepts a valid/ready stream of WIDTH-bit samples, registers each sample with its odd/even classification, and keeps saturating per-frame counts of even and odd samples. It emits a one-cycle frame summary when a sample flagged `in_last` is accepted. It sits between a sample producer and any downstream consumer that needs classified data plus per-frame statistics.

## Interface
- `WIDTH`, 8: sample width in bits, ≥ 1.
- `CNT_W`, 8: width of the even/odd frame counters, ≥ 2.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `in_data`  in  WIDTH  input sample, unsigned.
- `in_last`  in  1  sample is the last of its frame.
- `out_valid`  out  1  registered output sample valid.
- `out_ready`  in  1  downstream accepts the output sample.
- `out_data`  out  WIDTH  registered copy of the accepted sample.
- `out_is_even`  out  1  1 when `out_data[0]` is 0.
- `out_parity`  out  1  XOR-reduction of `out_data`; see Configuration.
- `frame_done`  out  1  one-cycle pulse: frame summary valid.
- `even_count`  out  CNT_W  even samples in the completed frame.
- `odd_count`  out  CNT_W  odd samples in the completed frame.

## Operation
- Accept = `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. Combinational, single output register, no skid buffer.
- On accept, the output register loads `out_data = in_data`, `out_is_even = ~in_data[0]` and `out_parity`, and `out_valid` is set.
- `out_valid` clears on `out_ready` when there is no simultaneous accept. When an accept happens in the same cycle, `out_valid` stays 1 and the register takes the new sample.
- Output register contents hold stable while `out_valid && !out_ready`.
- Internal counters `ev_acc`/`od_acc` (CNT_W bits):
  - An accepted sample increments the counter matching its bit 0.
  - Counters saturate at 2^CNT_W−1 and never wrap.
- Accept with `in_last = 1`:
  - `even_count`/`odd_count` load the totals including that last sample, saturated.
  - `frame_done` pulses high for exactly one cycle.
  - `ev_acc`/`od_acc` clear to 0, so the next accepted sample starts a new frame.
- `even_count`/`odd_count` hold their values until the next frame completes.
- A frame of one sample is legal: `in_last` on the first sample gives counts of 1/0 or 0/1.

## Timing
- Latency: 1 cycle from accept to `out_valid`. `frame_done` asserts in the same cycle that the final sample appears on `out_valid`.
- Back-to-back throughput is 1 sample/cycle while `out_ready` is held at 1.
- Reset (`reset` = 0, asynchronous) forces:
  - `out_valid` = 0, `out_data` = 0, `out_is_even` = 1, `out_parity` = 0;
  - `frame_done` = 0, `even_count` = 0, `odd_count` = 0, `ev_acc` = `od_acc` = 0.
- `in_ready` is 1 while out of reset with `out_valid` = 0.
- Reset asserted mid-frame discards the partial frame: no `frame_done` is issued and counters restart from 0.
- Deassertion is taken synchronously at the first rising `clk` edge after release; no accept occurs in that cycle's sampling before release.
- `in_data`/`in_last` are ignored when `in_valid` = 0.

## Configuration
- Macro `ODD_EVEN_PARITY_EN`.
  - Defined: `out_parity` is registered as `^in_data` on accept, with reset value 0.
  - Undefined: parity logic is not built and `out_parity` is tied to 0.
- The port list is identical in both builds.

## Test plan
- Reset mid-frame: accept 6, 11, assert `reset` low for 1 cycle, then accept 4 with `in_last` → `even_count` = 1, `odd_count` = 0; no `frame_done` before the reset.
- Single stream, `out_ready` = 1, WIDTH = 8: accept 6 then 11 (`in_last`) → cycle+1 `out_data` = 6, `out_is_even` = 1; cycle+2 `out_data` = 11, `out_is_even` = 0, `frame_done` = 1, `even_count` = 1, `odd_count` = 1.
- Backpressure: `out_ready` = 0 after accepting 9 → `in_ready` = 0, `out_data` holds 9 for 5 cycles. Raise `out_ready` with `in_valid` on data 2 → next cycle `out_data` = 2 and `out_valid` stays 1.
- Saturation, CNT_W = 2: stream 5 even samples, the last flagged → `even_count` = 3, `odd_count` = 0. Next frame, 1 odd sample with last → counts 0/1.
- Parity with the macro defined: accept 0xB7 → `out_parity` = 0; accept 0x07 → `out_parity` = 1. Macro undefined → `out_parity` = 0 for both.
- WIDTH = 1 build: alternate samples 0,1,0 (last) → `even_count` = 2, `odd_count` = 1, and `out_is_even` sequence is 1,0,1.
